// File: rtl/us_order_scheduler.sv
// -----------------------------------------------------------------------------
// us_order_scheduler
//   Accepts command words from two requesters through a round-robin arbiter,
//   keeps a count of pending imaging orders, adjusts a 12-bit transducer DAC
//   setpoint per order, and runs a capture sequencer that requests
//   IMGS_PER_ORDER image frames for each pending order.
//
// Command word: [0] on, [1] off, [2] increase, [3] decrease, [4] receive,
//               [5] send, [6] valid, [14:7] amount (DAC step = amount*16).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_data / req1_data      command words (DATA_WIDTH)
//   req0_valid / req1_valid    command offered
//   req0_ready / req1_ready    command taken when valid & ready
//   img_start                  one-cycle capture request
//   img_done                   one-cycle capture completion
//   outputDAC                  transducer drive setpoint (12 bits)
//   order_count                pending orders (0..MAX_ORDERS)
//   no_order                   no pending order, or reset asserted
//   finished_order, cmd_err    one-cycle status pulses
//
// Build option
//   US_SCHED_DAC_SAT_EN  defined: outputDAC saturates at 4095 / 0.
//                        undefined: outputDAC wraps modulo 4096.
// -----------------------------------------------------------------------------
module us_order_scheduler #(
  parameter int DATA_WIDTH     = 15,
  parameter int MAX_ORDERS     = 5,
  parameter int IMGS_PER_ORDER = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  img_start,
  input  logic                  img_done,
  output logic [11:0]           outputDAC,
  output logic [2:0]            order_count,
  output logic                  no_order,
  output logic                  finished_order,
  output logic                  cmd_err
);

  typedef struct packed {
    logic [7:0] amount;
    logic       valid;
    logic       send;
    logic       receive;
    logic       decrease;
    logic       increase;
    logic       off;
    logic       on;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT
  } state_t;

  localparam int              CNT_W     = (IMGS_PER_ORDER > 1) ? $clog2(IMGS_PER_ORDER) : 1;
  localparam logic [CNT_W-1:0] LAST_IMG = CNT_W'(IMGS_PER_ORDER - 1);
  localparam logic [2:0]      ORDER_MAX = 3'(MAX_ORDERS);

  logic [DATA_WIDTH-1:0] w_word;
  cmd_t                  w_cmd;
  logic                  w_gnt0, w_gnt1, w_room, w_abort_word;
  logic                  w_hs, w_abort, w_order, w_bad, w_last_img, w_finish;
  logic                  w_unused;
  logic [11:0]           w_step, w_dac_inc, w_dac_dec;
`ifdef US_SCHED_DAC_SAT_EN
  logic [12:0]           w_sum;
`endif
  state_t                r_state, w_state_nxt;
  logic                  r_prio1;       // 1: req1 holds the turn on a tie
  logic [2:0]            r_order_cnt;
  logic [CNT_W-1:0]      r_img_cnt;
  logic [11:0]           r_dac;
  logic                  r_finished, r_cmd_err;

  // ---------------- arbitration and decode ----------------
  assign w_gnt0       = req0_valid & (~req1_valid | ~r_prio1);
  assign w_gnt1       = req1_valid & (~req0_valid |  r_prio1);
  assign w_word       = w_gnt1 ? req1_data : req0_data;
  assign w_cmd        = cmd_t'(w_word[14:0]);
  assign w_abort_word = w_cmd.valid & w_cmd.off;
  assign w_room       = (r_order_cnt < ORDER_MAX);

  // An abort must get through even with a full queue, so readiness depends
  // on the offered word. Gating with rst_n keeps both readies low in reset.
  assign req0_ready = rst_n & w_gnt0 & (w_room | w_abort_word);
  assign req1_ready = rst_n & w_gnt1 & (w_room | w_abort_word);

  assign w_hs    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_abort = w_hs & w_abort_word;
  assign w_order = w_hs & w_cmd.valid & w_cmd.on & ~w_cmd.off & w_cmd.send
                 & ~(w_cmd.increase & w_cmd.decrease);
  assign w_bad   = w_hs & ~w_abort_word & ~w_order;

  // The receive bit and any bits above 14 carry no function.
  assign w_unused = ^{w_cmd.receive, w_word};

  assign w_last_img = (r_img_cnt == LAST_IMG);
  assign w_finish   = (r_state == ST_WAIT) & img_done & w_last_img;

  // ---------------- DAC step arithmetic ----------------
  always_comb begin
    w_step = {w_cmd.amount, 4'b0000};
`ifdef US_SCHED_DAC_SAT_EN
    w_sum     = {1'b0, r_dac} + {1'b0, w_step};
    w_dac_inc = w_sum[12] ? 12'hFFF : w_sum[11:0];
    w_dac_dec = (r_dac < w_step) ? 12'd0 : (r_dac - w_step);
`else
    w_dac_inc = r_dac + w_step;
    w_dac_dec = r_dac - w_step;
`endif
  end

  // ---------------- capture FSM ----------------
  // NOTE: state and counters use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    img_start   = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_order_cnt != 3'd0) w_state_nxt = ST_START;
      ST_START: begin
        img_start   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (img_done) w_state_nxt = w_last_img ? ST_IDLE : ST_START;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio1     <= 1'b0;
      r_order_cnt <= 3'd0;
      r_img_cnt   <= '0;
      r_dac       <= 12'd0;
      r_finished  <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      if (w_hs) r_prio1 <= w_gnt0;   // turn passes to the other requester
      r_cmd_err  <= w_bad;
      r_finished <= w_finish & ~w_abort;

      if (w_abort) begin
        r_order_cnt <= 3'd0;
        r_img_cnt   <= '0;
        r_dac       <= 12'd0;
      end else begin
        // Accept and finish in the same cycle cancel out.
        case ({w_order, w_finish})
          2'b10:   r_order_cnt <= r_order_cnt + 3'd1;
          2'b01:   r_order_cnt <= r_order_cnt - 3'd1;
          default: r_order_cnt <= r_order_cnt;
        endcase

        if ((r_state == ST_WAIT) && img_done)
          r_img_cnt <= w_last_img ? '0 : (r_img_cnt + CNT_W'(1));

        if (w_order && w_cmd.increase)      r_dac <= w_dac_inc;
        else if (w_order && w_cmd.decrease) r_dac <= w_dac_dec;
      end
    end
  end

  assign outputDAC      = r_dac;
  assign order_count    = r_order_cnt;
  assign no_order       = ~rst_n | (r_order_cnt == 3'd0);
  assign finished_order = r_finished;
  assign cmd_err        = r_cmd_err;

endmodule

// File: tb/tb_us_order_scheduler.sv
// -----------------------------------------------------------------------------
// tb_us_order_scheduler
//   Directed bench for us_order_scheduler. A behavioural model (order tally,
//   DAC value, images taken, whose turn it is) predicts every output each
//   cycle; directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_us_order_scheduler;

  localparam int IMGS = 50;
  localparam int MAXO = 5;

  // Command words (15 bits)
  localparam logic [14:0] W_NOP      = 15'h0000;  // no flags: error word
  localparam logic [14:0] W_ORD_INC3 = 15'h01E5;  // on|inc|send|valid, amount 3
  localparam logic [14:0] W_ORD      = 15'h0061;  // on|send|valid
  localparam logic [14:0] W_ABORT    = 15'h0042;  // off|valid
  localparam logic [14:0] W_INCDEC   = 15'h006D;  // on|inc|dec|send|valid
  localparam logic [14:0] W_INC255   = 15'h7FE5;  // amount 255 increase
  localparam logic [14:0] W_INC2     = 15'h0165;  // amount 2 increase

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [14:0] req0_data, req1_data;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic        img_start, img_done;
  logic [11:0] outputDAC;
  logic [2:0]  order_count;
  logic        no_order, finished_order, cmd_err;

  int n_tests = 0;
  int n_fail  = 0;
  int starts_seen = 0;
  int dones_sent  = 0;

  us_order_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_data      (req0_data),
    .req1_data      (req1_data),
    .req0_valid     (req0_valid),
    .req1_valid     (req1_valid),
    .req0_ready     (req0_ready),
    .req1_ready     (req1_ready),
    .img_start      (img_start),
    .img_done       (img_done),
    .outputDAC      (outputDAC),
    .order_count    (order_count),
    .no_order       (no_order),
    .finished_order (finished_order),
    .cmd_err        (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int count;      // orders pending
    int dac;        // setpoint
    int imgs;       // images completed for the current order
    bit turn1;      // requester 1 wins the next tie
    bit start;      // an image request is due this cycle
    bit open;       // an image request is outstanding
    bit fin;        // an order completed at the last edge
    bit err;        // an unusable word was taken at the last edge
  } model_t;

  model_t m = '{default: 0};

  function automatic bit exp_ready(input model_t s, input int k);
    bit          g0, g1, abort;
    logic [14:0] w;
    g0 = req0_valid && (!req1_valid || !s.turn1);
    g1 = req1_valid && (!req0_valid ||  s.turn1);
    w  = g1 ? req1_data : req0_data;
    abort = w[6] && w[1];
    if (rst_n !== 1'b1) return 1'b0;
    if (k == 0) return g0 && (s.count < MAXO || abort);
    return g1 && (s.count < MAXO || abort);
  endfunction

  function automatic int dac_up(input int d, input int step);
`ifdef US_SCHED_DAC_SAT_EN
    return (d + step > 4095) ? 4095 : d + step;
`else
    return (d + step) % 4096;
`endif
  endfunction

  function automatic int dac_down(input int d, input int step);
`ifdef US_SCHED_DAC_SAT_EN
    return (d - step < 0) ? 0 : d - step;
`else
    return (d - step + 4096) % 4096;
`endif
  endfunction

  function automatic model_t model_next(input model_t s);
    model_t      n;
    bit          hs0, hs1, hs, abort, order, fin;
    logic [14:0] w;
    n   = s;
    hs0 = req0_valid && exp_ready(s, 0);
    hs1 = req1_valid && exp_ready(s, 1);
    hs  = hs0 || hs1;
    w   = hs1 ? req1_data : req0_data;
    abort = hs && w[6] && w[1];
    order = hs && w[6] && w[0] && !w[1] && w[5] && !(w[2] && w[3]);
    n.err = hs && !abort && !order;
    if (hs) n.turn1 = hs0;
    n.fin = 1'b0;
    if (abort) begin
      n.count = 0; n.dac = 0; n.imgs = 0; n.start = 0; n.open = 0;
    end else begin
      fin = 1'b0;
      if (s.start) begin
        n.start = 0; n.open = 1;
      end else if (s.open) begin
        if (img_done) begin
          n.open = 0;
          n.imgs = s.imgs + 1;
          if (n.imgs == IMGS) begin fin = 1'b1; n.imgs = 0; end
          else n.start = 1;
        end
      end else if (s.count > 0) begin
        n.start = 1;
      end
      n.fin   = fin;
      n.count = s.count + int'(order) - int'(fin);
      if (order && w[2])      n.dac = dac_up(s.dac, int'(w[14:7]) * 16);
      else if (order && w[3]) n.dac = dac_down(s.dac, int'(w[14:7]) * 16);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("req0_ready",     req0_ready,     exp_ready(m, 0));
    check("req1_ready",     req1_ready,     exp_ready(m, 1));
    check("img_start",      img_start,      m.start);
    check("outputDAC",      outputDAC,      m.dac);
    check("order_count",    order_count,    m.count);
    check("no_order",       no_order,       (m.count == 0 || rst_n !== 1'b1) ? 1 : 0);
    check("finished_order", finished_order, m.fin);
    check("cmd_err",        cmd_err,        m.err);
    if (img_start === 1'b1) starts_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int port, input logic [14:0] w);
    bit ok;
    @(posedge clk); #1;
    if (port == 0) begin req0_data = w; req0_valid = 1'b1; end
    else           begin req1_data = w; req1_valid = 1'b1; end
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin ok = 1'b1; break; end
    end
    check("send_handshake", ok, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (starts_seen > dones_sent) begin ok = 1'b1; break; end
    end
    check("capture_start_seen", ok, 1);
  endtask

  task automatic do_capture();
    wait_start();
    @(posedge clk); #1 img_done = 1'b1;
    dones_sent++;
    @(posedge clk); #1 img_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    req0_data = W_ORD_INC3; req1_data = W_NOP;
    req0_valid = 1'b1; req1_valid = 1'b0; img_done = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state, with an order being offered
    repeat (2) @(negedge clk);
    check("rst_order_count", order_count, 0);
    check("rst_no_order",    no_order,    1);
    check("rst_dac",         outputDAC,   0);
    check("rst_ready0",      req0_ready,  0);
    check("rst_img_start",   img_start,   0);
    @(posedge clk); #1 req0_valid = 1'b0; req0_data = W_NOP;
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin on a sustained tie: req0, req1, req0, req1
    @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      check("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      if (k == 1) check("rr_cmd_err", cmd_err, 1);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;

    // First order: amount 3 increase
    send(0, W_ORD_INC3);
    @(negedge clk);
    check("ord1_count", order_count, 1);
    check("ord1_dac",   outputDAC,   48);
    check("ord1_start_not_yet", img_start, 0);
    @(negedge clk);
    check("ord1_img_start", img_start, 1);

    // 50 captures finish the order
    for (int i = 0; i < IMGS; i++) do_capture();
    @(negedge clk);
    check("fin_pulse",    finished_order, 1);
    check("fin_count",    order_count,    0);
    check("fin_no_order", no_order,       1);
    c = 0;
    repeat (5) begin
      @(negedge clk);
      if (img_start || finished_order) c++;
    end
    check("fin_idle_quiet", c, 0);

    // increase & decrease together is not an order
    send(0, W_INCDEC);
    @(negedge clk);
    check("incdec_cmd_err", cmd_err,     1);
    check("incdec_count",   order_count, 0);

    // Six back-to-back orders with no captures finished
    @(posedge clk); #1 req0_data = W_ORD; req0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("full_ready0", req0_ready,  (k < 5) ? 1 : 0);
      check("full_count",  order_count, k);
    end
    repeat (3) begin
      @(negedge clk);
      check("full_hold_ready0", req0_ready, 0);
    end
    for (int i = 0; i < IMGS; i++) do_capture();
    @(negedge clk);
    check("full_fin_count", order_count,    4);
    check("full_fin_pulse", finished_order, 1);
    check("full_6th_ready", req0_ready,     1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("full_refill_count", order_count, 5);

    // Abort from req1 while the queue is full
    send(1, W_ABORT);
    @(negedge clk);
    check("abort1_count",    order_count, 0);
    check("abort1_dac",      outputDAC,   0);
    check("abort1_no_order", no_order,    1);
    repeat (2) @(negedge clk);
    dones_sent = starts_seen;

    // DAC near the top plus amount 2
    send(0, W_INC255);
    @(negedge clk);
    check("dac_4080", outputDAC, 4080);
    send(0, W_INC2);
    @(negedge clk);
`ifdef US_SCHED_DAC_SAT_EN
    check("dac_sat_4095", outputDAC, 4095);
`else
    check("dac_wrap_16", outputDAC, 16);
`endif
    check("two_orders", order_count, 2);

    // Abort while waiting on image 30 of the first of two orders
    for (int i = 0; i < 29; i++) do_capture();
    wait_start();
    send(0, W_ABORT);
    @(negedge clk);
    check("abort2_count", order_count,    0);
    check("abort2_dac",   outputDAC,      0);
    check("abort2_fin",   finished_order, 0);
    dones_sent = starts_seen;
    @(posedge clk); #1 img_done = 1'b1;
    @(posedge clk); #1 img_done = 1'b0;
    c = 0;
    repeat (5) begin
      @(negedge clk);
      if (img_start || finished_order || order_count != 3'd0) c++;
    end
    check("abort2_done_ignored", c, 0);

    // Asynchronous reset in the middle of a capture
    send(0, W_ORD_INC3);
    wait_start();
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_rst_count",    order_count, 0);
    check("async_rst_dac",      outputDAC,   0);
    check("async_rst_no_order", no_order,    1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    dones_sent = starts_seen;
    @(posedge clk); #1 img_done = 1'b1;
    @(posedge clk); #1 img_done = 1'b0;
    c = 0;
    repeat (5) begin
      @(negedge clk);
      if (img_start || finished_order) c++;
    end
    check("rst_done_ignored", c, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
